// File: rtl/lfsr_prbs_checker_if.sv
// lfsr_prbs_checker_if
//   Bundles the serial PRBS input and the checker's status outputs.
//   master : stream source / status consumer (drives bit_in, bit_valid, clear)
//   slave  : the checker (drives locked, err_pulse, sync_lost, err_cnt, bit_cnt)
interface lfsr_prbs_checker_if #(
    parameter int unsigned ERR_W = 16
) ();
    logic             bit_in;
    logic             bit_valid;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic             sync_lost;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] bit_cnt;

    modport master (
        output bit_in, bit_valid, clear,
        input  locked, err_pulse, sync_lost, err_cnt, bit_cnt
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output locked, err_pulse, sync_lost, err_cnt, bit_cnt
    );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker
//   Self-synchronising Fibonacci-LFSR PRBS checker. Loads a local LFSR from the
//   received stream, verifies it over LOCK_COUNT bits, then free-runs and counts
//   bit errors. Too many errors inside one WINDOW-bit block forces a resync.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-low reset
//     bus  : slave modport -- bit_in/bit_valid/clear in;
//            locked/err_pulse/sync_lost/err_cnt/bit_cnt out
module lfsr_prbs_checker #(
    parameter int unsigned       LENGTH      = 16,
    parameter logic [0:LENGTH-1] TAPS        = 16'b0110100000000001,
    parameter int unsigned       LOCK_COUNT  = 32,
    parameter int unsigned       WINDOW      = 64,
    parameter int unsigned       LOSS_THRESH = 8,
    parameter int unsigned       ERR_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_prbs_checker_if.slave bus
);

    localparam int unsigned FILL_W  = $clog2(LENGTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
    localparam int unsigned BLK_W   = $clog2(LOSS_THRESH + 1);

    // Counters are compared against "last value before reaching the limit" so
    // that the current bit is included in the limit test.
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LENGTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [0:LENGTH-1]   sr_q, sr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic                sync_lost_q, sync_lost_d;
    logic                pred;
    logic                err;
    logic                hit;
    logic                lose;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            blk_q       <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            blk_q       <= blk_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    // Next-state logic
    always_comb begin
        pred    = ^(TAPS & sr_q);
        err     = bus.bit_in ^ pred;
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        blk_d   = blk_q;
        hit     = 1'b0;
        lose    = 1'b0;
        if (bus.bit_valid) begin
            unique case (state_q)
                SEARCH: begin
                    sr_d = {bus.bit_in, sr_q[0:LENGTH-2]};
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_d = {bus.bit_in, sr_q[0:LENGTH-2]};
                    // All-zero register can never be a legal LFSR state.
                    if (!err && (sr_q != '0)) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            blk_d   = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        // The failing bit is already in sr, so it counts as fill.
                        state_d = SEARCH;
                        fill_d  = FILL_W'(1);
                    end
                end
                LOCKED: begin
                    // Local LFSR free-runs; received errors never enter sr.
                    sr_d = {pred, sr_q[0:LENGTH-2]};
                    hit  = err;
                    if (err && (blk_q == BLK_LAST)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        lose    = 1'b1;
                    end else if (win_q == WIN_LAST) begin
                        win_d = '0;
                        blk_d = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                        blk_d = blk_q + BLK_W'(err);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Output logic: pulses, saturating counters and port drive
    always_comb begin
        err_pulse_d = hit;
        sync_lost_d = lose;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        if (bus.bit_valid && (state_q == LOCKED)) begin
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + ERR_W'(1);
            if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        // clear overrides any increment; it acts even on idle cycles.
        if (bus.clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
        bus.locked    = (state_q == LOCKED);
        bus.err_pulse = err_pulse_q;
        bus.sync_lost = sync_lost_q;
        bus.err_cnt   = err_cnt_q;
        bus.bit_cnt   = bit_cnt_q;
    end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker
//   Drives two checkers (ERR_W=16 and ERR_W=4) from one PRBS source and
//   compares both against a behavioural model of the lock/count rules.
module tb_lfsr_prbs_checker;

    localparam int unsigned LENGTH      = 16;
    localparam logic [0:15] TAPS        = 16'b0110100000000001;
    localparam int unsigned LOCK_COUNT  = 32;
    localparam int unsigned WINDOW      = 64;
    localparam int unsigned LOSS_THRESH = 8;

    logic clk = 1'b0;
    logic rst;
    logic bit_in, bit_valid, clear;

    always #5 clk = ~clk;

    lfsr_prbs_checker_if #(.ERR_W(16)) bus16 ();
    lfsr_prbs_checker_if #(.ERR_W(4))  bus4 ();

    assign bus16.bit_in    = bit_in;
    assign bus16.bit_valid = bit_valid;
    assign bus16.clear     = clear;
    assign bus4.bit_in     = bit_in;
    assign bus4.bit_valid  = bit_valid;
    assign bus4.clear      = clear;

    lfsr_prbs_checker #(
        .LENGTH(LENGTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(16)
    ) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    lfsr_prbs_checker #(
        .LENGTH(LENGTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(4)
    ) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- PRBS source (generator view) ----------------
    logic [0:15] g = 16'hACE1;

    task automatic gen_bit(output bit b);
        bit fb;
        b  = g[15];
        fb = ^(TAPS & g);
        g  = {fb, g[0:14]};
    endtask

    // ---------------- behavioural reference ----------------
    // mode: 0 = hunting (loading), 1 = confirming, 2 = locked
    int    m_mode, m_fill, m_match, m_win, m_blk;
    longint m_errs, m_bits;
    bit    m_hist[LENGTH];   // m_hist[0] = most recently accepted bit
    bit    e_pulse, e_lost;

    task automatic m_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_blk = 0;
        m_errs = 0; m_bits = 0; e_pulse = 0; e_lost = 0;
        for (int i = 0; i < LENGTH; i++) m_hist[i] = 0;
    endtask

    function automatic bit m_pred();
        bit p = 0;
        for (int i = 0; i < LENGTH; i++) if (TAPS[i]) p ^= m_hist[i];
        return p;
    endfunction

    task automatic m_push(input bit b);
        for (int i = LENGTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = b;
    endtask

    task automatic m_step(input bit b, input bit v, input bit c);
        bit p, nz;
        e_pulse = 0;
        e_lost  = 0;
        if (v) begin
            p  = m_pred();
            nz = 0;
            for (int i = 0; i < LENGTH; i++) nz |= m_hist[i];
            if (m_mode == 0) begin
                m_push(b);
                m_fill++;
                if (m_fill == LENGTH) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                m_push(b);
                if (b == p && nz) begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin m_mode = 2; m_win = 0; m_blk = 0; end
                end else begin
                    m_mode = 0; m_fill = 1;
                end
            end else begin
                m_push(p);
                m_bits++;
                if (b != p) begin m_errs++; m_blk++; e_pulse = 1; end
                m_win++;
                if (m_blk >= LOSS_THRESH) begin
                    m_mode = 0; m_fill = 0; e_lost = 1;
                end else if (m_win == WINDOW) begin
                    m_win = 0; m_blk = 0;
                end
            end
        end
        if (c) begin m_errs = 0; m_bits = 0; end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    task automatic check_all();
        chk("locked16",    32'(bus16.locked),    32'(m_mode == 2));
        chk("locked4",     32'(bus4.locked),     32'(m_mode == 2));
        chk("err_pulse",   32'(bus16.err_pulse), 32'(e_pulse));
        chk("sync_lost",   32'(bus16.sync_lost), 32'(e_lost));
        chk("err_cnt16",   32'(bus16.err_cnt),   sat(m_errs, 16));
        chk("bit_cnt16",   32'(bus16.bit_cnt),   sat(m_bits, 16));
        chk("err_cnt4",    32'(bus4.err_cnt),    sat(m_errs, 4));
        chk("bit_cnt4",    32'(bus4.bit_cnt),    sat(m_bits, 4));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step_raw(input bit b, input bit v, input bit c);
        bit_in    = b;
        bit_valid = v;
        clear     = c;
        m_step(b, v, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic step(input bit inv, input bit v, input bit c);
        bit b;
        if (v) begin
            gen_bit(b);
            b ^= inv;
        end else begin
            b = 1'($urandom);
        end
        step_raw(b, v, c);
    endtask

    task automatic do_reset();
        bit_in = 0; bit_valid = 0; clear = 0;
        rst = 1'b0;
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic align_window();
        int guard = 0;
        while (m_win != 0 && guard < 2 * WINDOW) begin
            step(0, 1, 0);
            guard++;
        end
        chk("window_align", 32'(m_win), 32'd0);
    endtask

    typedef struct {
        bit v;
        bit inv;
        bit clr;
        bit e_locked;
        bit e_pulse;
        int e_errcnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nv;
        // Hand-derived sequence applied to a freshly locked, error-free link.
        tbl[0] = '{v:1, inv:0, clr:0, e_locked:1, e_pulse:0, e_errcnt:0};
        tbl[1] = '{v:1, inv:1, clr:0, e_locked:1, e_pulse:1, e_errcnt:1};
        tbl[2] = '{v:0, inv:1, clr:0, e_locked:1, e_pulse:0, e_errcnt:1};
        tbl[3] = '{v:1, inv:0, clr:0, e_locked:1, e_pulse:0, e_errcnt:1};
        tbl[4] = '{v:1, inv:1, clr:1, e_locked:1, e_pulse:1, e_errcnt:0};
        tbl[5] = '{v:1, inv:1, clr:0, e_locked:1, e_pulse:1, e_errcnt:1};
        tbl[6] = '{v:1, inv:0, clr:1, e_locked:1, e_pulse:0, e_errcnt:0};
        tbl[7] = '{v:0, inv:0, clr:0, e_locked:1, e_pulse:0, e_errcnt:0};

        do_reset();
        chk("reset_locked",  32'(bus16.locked),  32'd0);
        chk("reset_err_cnt", 32'(bus16.err_cnt), 32'd0);

        // Clean stream: lock exactly on the 48th bit.
        for (int n = 1; n <= 48; n++) begin
            step(0, 1, 0);
            chk("lock_latency", 32'(bus16.locked), 32'(n == 48));
        end
        for (int n = 1; n <= 5; n++) step(0, 1, 0);
        chk("bits_after_lock", 32'(bus16.bit_cnt), 32'd5);
        chk("no_errors",       32'(bus16.err_cnt), 32'd0);

        // Single errors, idle cycles, clear-vs-increment.
        foreach (tbl[i]) begin
            step(tbl[i].inv, tbl[i].v, tbl[i].clr);
            chk("tbl_locked",  32'(bus16.locked),    32'(tbl[i].e_locked));
            chk("tbl_pulse",   32'(bus16.err_pulse), 32'(tbl[i].e_pulse));
            chk("tbl_err_cnt", 32'(bus16.err_cnt),   32'(tbl[i].e_errcnt));
        end

        // Eight errors in one block force resync, then relock after 48 bits.
        align_window();
        for (int n = 1; n <= 8; n++) begin
            step(1, 1, 0);
            chk("burst_locked", 32'(bus16.locked),    32'(n < 8));
            chk("burst_lost",   32'(bus16.sync_lost), 32'(n == 8));
        end
        for (int n = 1; n <= 48; n++) begin
            step(0, 1, 0);
            chk("relock_latency", 32'(bus16.locked), 32'(n == 48));
        end

        // Seven errors in each of two adjacent blocks: no resync.
        step(0, 1, 1);
        align_window();
        for (int n = 0; n < 2 * WINDOW; n++) step(((n % WINDOW) < 7) ? 1'b1 : 1'b0, 1, 0);
        chk("two_blocks_locked",  32'(bus16.locked),  32'd1);
        chk("two_blocks_err_cnt", 32'(bus16.err_cnt), 32'd14);

        // 20 spread errors: 4-bit counter saturates.
        step(0, 1, 1);
        for (int n = 0; n < 200; n++) step((n % 10) == 0 ? 1'b1 : 1'b0, 1, 0);
        chk("sat_err_cnt4",  32'(bus4.err_cnt),  32'd15);
        chk("sat_err_cnt16", 32'(bus16.err_cnt), 32'd20);
        chk("sat_bit_cnt4",  32'(bus4.bit_cnt),  32'd15);
        step(1, 1, 1);
        chk("clr_err_cnt4",  32'(bus4.err_cnt),    32'd0);
        chk("clr_err_cnt16", 32'(bus16.err_cnt),   32'd0);
        chk("clr_pulse",     32'(bus16.err_pulse), 32'd1);

        // All-zero input never locks.
        do_reset();
        for (int n = 0; n < 200; n++) step_raw(0, 1, 0);
        chk("zeros_never_lock", 32'(bus16.locked), 32'd0);

        // 50% bit_valid on a clean stream: lock after 48 valid bits.
        do_reset();
        nv = 0;
        for (int n = 0; n < 400 && nv < 48; n++) begin
            bit v;
            v = 1'($urandom);
            step(0, v, 0);
            if (v) nv++;
            chk("gapped_lock", 32'(bus16.locked), 32'(nv >= 48));
        end
        chk("gapped_lock_reached", 32'(nv), 32'd48);

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bit v, inv, c;
            v   = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 99) < 3);
            c   = ($urandom_range(0, 199) == 0);
            step(inv, v, c);
        end

        // Asynchronous reset while locked.
        do_reset();
        for (int n = 0; n < 60; n++) step(n == 55 ? 1'b1 : 1'b0, 1, 0);
        chk("pre_reset_locked", 32'(bus16.locked), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_locked",    32'(bus16.locked),    32'd0);
        chk("arst_err_pulse", 32'(bus16.err_pulse), 32'd0);
        chk("arst_sync_lost", 32'(bus16.sync_lost), 32'd0);
        chk("arst_err_cnt",   32'(bus16.err_cnt),   32'd0);
        chk("arst_bit_cnt",   32'(bus16.bit_cnt),   32'd0);
        m_reset();
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
